// File: rtl/ifetch_mem_responder_pkg.sv
// Shared constants and encodings for the instruction-fetch memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ifetch_mem_responder_pkg;

    localparam int XLEN = 32;

    // Address map: PC[31:28] selects the memory region.
    localparam logic [3:0] BIOS_REGION = 4'h4;
    localparam logic [3:0] IMEM_REGION = 4'h1;

    // Word returned for an unmapped or misaligned fetch (addi x0,x0,0).
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    // The fetch reset vector sits at the base of the BIOS region.
    localparam logic [XLEN-1:0] RESET_PC = 32'h4000_0000;

    typedef enum logic [1:0] {
        RGN_ERR  = 2'd0,
        RGN_BIOS = 2'd1,
        RGN_IMEM = 2'd2
    } region_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } fsm_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ifetch_region_decode.sv
// Decodes a fetch PC into BIOS / IMEM / ERR region; misaligned PCs are ERR.
// Latency: combinational, 0 cycles.
// Backpressure: none (pure function of pc).
// Ports: pc (byte address in), region (decoded region out), err (region is ERR).
module ifetch_region_decode
    import ifetch_mem_responder_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    output region_t         region,
    output logic            err
);

    // Only the region nibble and the alignment bits matter here.
    logic unused_pc_bits;
    assign unused_pc_bits = ^pc[27:2];

    always_comb begin
        region = RGN_ERR;
        if (pc[1:0] == 2'b00) begin
            if (pc[31:28] == BIOS_REGION) begin
                region = RGN_BIOS;
            end else if (pc[31:28] == IMEM_REGION) begin
                region = RGN_IMEM;
            end
        end
    end

    assign err = (region == RGN_ERR);

endmodule

// File: rtl/ifetch_mem_responder.sv
// Memory-side responder for instruction fetch: decodes PC, drives BRAM word addresses, returns the word.
// Latency: accept -> resp_valid is 1 cycle for IMEM/ERR, 1+BIOS_WAIT cycles for BIOS.
// Backpressure: resp_ready low holds the response stable and drops req_ready; flush kills everything.
// Ports: clk/rst (sync, active-high); req_valid/req_pc/req_ready (PC request); flush (redirect);
//        resp_valid/resp_ready/resp_instr/resp_err (instruction return); bios_addr/bios_dout and
//        imem_addr/imem_dout (synchronous-read BRAMs); fetch_cnt/stall_cnt (perf counters).
// Build option: define IFETCH_PERF_CNT_EN to enable fetch_cnt/stall_cnt; otherwise both read 0.
module ifetch_mem_responder #(
    parameter int          BIOS_AW   = 12,
    parameter int          IMEM_AW   = 14,
    parameter int          BIOS_WAIT = 1,
    parameter logic [31:0] NOP_INSTR = ifetch_mem_responder_pkg::NOP_INSTR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    input  logic [31:0]        req_pc,
    output logic               req_ready,
    input  logic               flush,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [31:0]        resp_instr,
    output logic               resp_err,
    output logic [BIOS_AW-1:0] bios_addr,
    input  logic [31:0]        bios_dout,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_dout,
    output logic [31:0]        fetch_cnt,
    output logic [31:0]        stall_cnt
);
    import ifetch_mem_responder_pkg::*;

    localparam int         AW_MAX    = max_int(BIOS_AW, IMEM_AW);
    localparam logic [3:0] WAIT_INIT = 4'((BIOS_WAIT > 0) ? BIOS_WAIT - 1 : 0);

    fsm_state_t  state_q;
    region_t     rgn_q;
    region_t     dec_rgn;
    logic        err_q;
    logic        dec_err;
    logic [31:0] pc_q;
    logic [31:0] hold_q;
    logic [31:0] addr_pc;
    logic [31:0] sel_dout;
    logic [3:0]  wcnt_q;
    logic        resp_vld_q;
    logic        first_q;
    logic        accept;
    logic        acc_to_wait;
    logic        unused_addr_bits;

    ifetch_region_decode u_decode (
        .pc     (req_pc),
        .region (dec_rgn),
        .err    (dec_err)
    );

    // Ready in IDLE, or in RESP when the current word is being consumed (back-to-back).
    assign req_ready   = !flush && ((state_q == ST_IDLE) ||
                                    ((state_q == ST_RESP) && resp_ready));
    assign accept      = req_valid && req_ready;
    assign acc_to_wait = (dec_rgn == RGN_BIOS) && (BIOS_WAIT != 0);

    // The BRAMs sample the new PC in the accept cycle; afterwards the latched PC keeps
    // the address stable so the read data stays valid through WAIT and RESP.
    assign addr_pc          = accept ? req_pc : pc_q;
    assign bios_addr        = addr_pc[BIOS_AW+1:2];
    assign imem_addr        = addr_pc[IMEM_AW+1:2];
    assign unused_addr_bits = ^{addr_pc[31:AW_MAX+2], addr_pc[1:0]};

    always_comb begin
        sel_dout = NOP_INSTR;
        case (rgn_q)
            RGN_BIOS: sel_dout = bios_dout;
            RGN_IMEM: sel_dout = imem_dout;
            default:  sel_dout = NOP_INSTR;
        endcase
    end

    // Only the first RESP cycle is guaranteed to see fresh BRAM data; later cycles
    // replay the captured copy so a decode stall sees a stable word.
    assign resp_valid = resp_vld_q && !flush;
    assign resp_instr = first_q ? sel_dout : hold_q;
    assign resp_err   = resp_valid && err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rgn_q      <= RGN_ERR;
            err_q      <= 1'b0;
            pc_q       <= '0;
            hold_q     <= NOP_INSTR;
            wcnt_q     <= '0;
            resp_vld_q <= 1'b0;
            first_q    <= 1'b0;
        end else begin
            first_q <= 1'b0;
            if ((state_q == ST_RESP) && first_q) begin
                hold_q <= sel_dout;
            end

            if (flush) begin
                state_q    <= ST_IDLE;
                resp_vld_q <= 1'b0;
            end else if (accept) begin
                pc_q   <= req_pc;
                rgn_q  <= dec_rgn;
                err_q  <= dec_err;
                wcnt_q <= WAIT_INIT;
                if (acc_to_wait) begin
                    state_q    <= ST_WAIT;
                    resp_vld_q <= 1'b0;
                end else begin
                    state_q    <= ST_RESP;
                    resp_vld_q <= 1'b1;
                    first_q    <= 1'b1;
                end
            end else begin
                case (state_q)
                    ST_WAIT: begin
                        if (wcnt_q == 4'd0) begin
                            state_q    <= ST_RESP;
                            resp_vld_q <= 1'b1;
                            first_q    <= 1'b1;
                        end else begin
                            wcnt_q <= wcnt_q - 4'd1;
                        end
                    end
                    ST_RESP: begin
                        if (resp_ready) begin
                            state_q    <= ST_IDLE;
                            resp_vld_q <= 1'b0;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] fetch_q;
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_q <= '0;
            stall_q <= '0;
        end else begin
            if (accept) begin
                fetch_q <= fetch_q + 32'd1;
            end
            if (req_valid && !req_ready) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    assign fetch_cnt = fetch_q;
    assign stall_cnt = stall_q;
`else
    assign fetch_cnt = 32'h0;
    assign stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_ifetch_mem_responder.sv
// Self-checking bench for ifetch_mem_responder: vector table, corner-case sequences, random vs. model.
// Latency: n/a.
// Backpressure: exercised via resp_ready and flush.
module tb_ifetch_mem_responder;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int NV = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance (BIOS_WAIT = 1)
    logic        rst, req_valid, flush, resp_ready, scramble;
    logic [31:0] req_pc;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_instr, fetch_cnt, stall_cnt;
    logic [11:0] bios_addr;
    logic [13:0] imem_addr;
    logic [31:0] bios_dout, imem_dout;

    // second instance (BIOS_WAIT = 3)
    logic        req_valid3, flush3, resp_ready3;
    logic [31:0] req_pc3;
    logic        req_ready3, resp_valid3, resp_err3;
    logic [31:0] resp_instr3, fetch_cnt3, stall_cnt3;
    logic [11:0] bios_addr3;
    logic [13:0] imem_addr3;
    logic [31:0] bios_dout3, imem_dout3;

    ifetch_mem_responder #(.BIOS_AW(12), .IMEM_AW(14), .BIOS_WAIT(1), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_pc(req_pc), .req_ready(req_ready),
        .flush(flush), .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_instr(resp_instr),
        .resp_err(resp_err), .bios_addr(bios_addr), .bios_dout(bios_dout), .imem_addr(imem_addr),
        .imem_dout(imem_dout), .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
    );

    ifetch_mem_responder #(.BIOS_AW(12), .IMEM_AW(14), .BIOS_WAIT(3), .NOP_INSTR(NOP)) dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid3), .req_pc(req_pc3), .req_ready(req_ready3),
        .flush(flush3), .resp_valid(resp_valid3), .resp_ready(resp_ready3), .resp_instr(resp_instr3),
        .resp_err(resp_err3), .bios_addr(bios_addr3), .bios_dout(bios_dout3), .imem_addr(imem_addr3),
        .imem_dout(imem_dout3), .fetch_cnt(fetch_cnt3), .stall_cnt(stall_cnt3)
    );

    function automatic logic [31:0] bios_word(input logic [11:0] a);
        return 32'hDEAD_BEEF ^ {20'h0, a};
    endfunction

    function automatic logic [31:0] imem_word(input logic [13:0] a);
        return 32'h1E00_0000 ^ {18'h0, a};
    endfunction

    // Synchronous-read BRAM models; scramble corrupts data to prove the response is held.
    always @(posedge clk) begin
        bios_dout  <= scramble ? $urandom : bios_word(bios_addr);
        imem_dout  <= scramble ? $urandom : imem_word(imem_addr);
        bios_dout3 <= bios_word(bios_addr3);
        imem_dout3 <= imem_word(imem_addr3);
    end

    // Reference rules from the address map.
    function automatic logic is_bios(input logic [31:0] pc);
        return (pc[31:28] == 4'h4) && (pc[1:0] == 2'b00);
    endfunction
    function automatic logic is_imem(input logic [31:0] pc);
        return (pc[31:28] == 4'h1) && (pc[1:0] == 2'b00);
    endfunction
    function automatic logic err_of(input logic [31:0] pc);
        return !is_bios(pc) && !is_imem(pc);
    endfunction
    function automatic logic [31:0] word_of(input logic [31:0] pc);
        if (is_bios(pc)) return bios_word(pc[13:2]);
        if (is_imem(pc)) return imem_word(pc[15:2]);
        return NOP;
    endfunction
    function automatic int lat_of(input logic [31:0] pc, input int bw);
        return is_bios(pc) ? 1 + bw : 1;
    endfunction
    function automatic logic [31:0] rand_pc();
        logic [31:0] p;
        p = $urandom;
        case ($urandom_range(0, 5))
            0, 1:    p[31:28] = 4'h4;
            2, 3:    p[31:28] = 4'h1;
            default: p[31:28] = p[31:28];
        endcase
        if ($urandom_range(0, 7) != 0) p[1:0] = 2'b00;
        return p;
    endfunction

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        err;
        int          lat;
        logic [11:0] baddr;
        logic [13:0] iaddr;
    } vec_t;

    vec_t vecs[NV];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          have;
        int          rdy_at;
        logic [31:0] m_pc, m_instr;
        logic        m_err, e_rv, e_rr, acc;
        int          m_fetch, m_stall;

        vecs[0] = '{32'h4000_0000, 32'hDEAD_BEEF, 1'b0, 2, 12'h000, 14'h0000};
        vecs[1] = '{32'h1000_0000, 32'h1E00_0000, 1'b0, 1, 12'h000, 14'h0000};
        vecs[2] = '{32'h1000_0004, 32'h1E00_0001, 1'b0, 1, 12'h001, 14'h0001};
        vecs[3] = '{32'h2000_0000, NOP,           1'b1, 1, 12'h000, 14'h0000};
        vecs[4] = '{32'h1000_0002, NOP,           1'b1, 1, 12'h000, 14'h0000};
        vecs[5] = '{32'h4000_0FFC, 32'hDEAD_BD10, 1'b0, 2, 12'h3FF, 14'h03FF};
        vecs[6] = '{32'h1000_FFFC, 32'h1E00_3FFF, 1'b0, 1, 12'hFFF, 14'h3FFF};
        vecs[7] = '{32'h4000_0001, NOP,           1'b1, 1, 12'h000, 14'h0000};
        vecs[8] = '{32'hF000_0010, NOP,           1'b1, 1, 12'h004, 14'h0004};
        vecs[9] = '{32'h4FFF_FFFC, 32'hDEAD_B110, 1'b0, 2, 12'hFFF, 14'h3FFF};

        rst = 1; req_valid = 0; req_pc = 0; flush = 0; resp_ready = 1; scramble = 0;
        req_valid3 = 0; req_pc3 = 0; flush3 = 0; resp_ready3 = 1;
        repeat (3) tick();
        rst = 0; #1;
        chk("reset_req_ready", req_ready, 1);
        chk("reset_resp_valid", resp_valid, 0);
        chk("reset_resp_err", resp_err, 0);
        chk("reset_resp_instr", resp_instr, NOP);
        chk("reset_fetch_cnt", fetch_cnt, 0);
        chk("reset_stall_cnt", stall_cnt, 0);
        tick();

        // Vector table: one isolated request each, resp_ready held high.
        for (int i = 0; i < NV; i++) begin
            req_valid = 1; req_pc = vecs[i].pc; #1;
            chk("vec_req_ready", req_ready, 1);
            chk("vec_bios_addr", bios_addr, vecs[i].baddr);
            chk("vec_imem_addr", imem_addr, vecs[i].iaddr);
            tick();
            req_valid = 0; req_pc = 0;
            for (int k = 1; k <= vecs[i].lat; k++) begin
                #1;
                chk("vec_resp_valid", resp_valid, (k == vecs[i].lat) ? 1 : 0);
                chk("vec_bios_addr_hold", bios_addr, vecs[i].baddr);
                if (k == vecs[i].lat) begin
                    chk("vec_resp_instr", resp_instr, vecs[i].instr);
                    chk("vec_resp_err", resp_err, vecs[i].err);
                end
                tick();
            end
        end

        // IMEM streaming: one response per cycle.
        for (int c = 0; c < 4; c++) begin
            if (c < 3) begin
                req_valid = 1; req_pc = 32'h1000_0000 + 32'(4 * c);
            end else begin
                req_valid = 0;
            end
            #1;
            if (c < 3) begin
                chk("stream_req_ready", req_ready, 1);
                chk("stream_imem_addr", imem_addr, 32'(c));
            end
            chk("stream_resp_valid", resp_valid, (c > 0) ? 1 : 0);
            if (c > 0) chk("stream_resp_instr", resp_instr, imem_word(14'(c - 1)));
            tick();
        end
        #1; chk("stream_idle", resp_valid, 0); tick();

        // Decode stall: response must stay stable while BRAM data changes.
        req_valid = 1; req_pc = 32'h1000_0010; resp_ready = 0; #1;
        chk("hold_accept", req_ready, 1); tick();
        req_valid = 0; #1;
        chk("hold_first_valid", resp_valid, 1);
        chk("hold_first_instr", resp_instr, imem_word(14'd4));
        scramble = 1; tick();
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("hold_valid", resp_valid, 1);
            chk("hold_instr", resp_instr, imem_word(14'd4));
            chk("hold_req_ready", req_ready, 0);
            tick();
        end
        scramble = 0; resp_ready = 1; #1;
        chk("hold_release_instr", resp_instr, imem_word(14'd4));
        chk("hold_release_rdy", req_ready, 1);
        tick();
        #1; chk("hold_done", resp_valid, 0); tick();

        // Flush while a response is held.
        req_valid = 1; req_pc = 32'h1000_0020; resp_ready = 0; #1; tick();
        req_pc = 32'h1000_0024; flush = 1; #1;
        chk("flush_resp_drop", resp_valid, 0);
        chk("flush_req_ready", req_ready, 0);
        tick();
        flush = 0; resp_ready = 1; #1;
        chk("flush_after_valid", resp_valid, 0);
        chk("flush_after_ready", req_ready, 1);
        tick();
        req_valid = 0; #1;
        chk("flush_next_valid", resp_valid, 1);
        chk("flush_next_instr", resp_instr, imem_word(14'd9));
        tick();

        // BIOS_WAIT=3 instance: full latency, then flush mid-WAIT.
        req_valid3 = 1; req_pc3 = 32'h4000_0008; #1; tick();
        req_valid3 = 0;
        for (int k = 1; k <= 4; k++) begin
            #1;
            chk("w3_resp_valid", resp_valid3, (k == 4) ? 1 : 0);
            if (k == 4) chk("w3_resp_instr", resp_instr3, bios_word(12'd2));
            tick();
        end
        req_valid3 = 1; req_pc3 = 32'h4000_0000; #1;
        chk("w3_accept", req_ready3, 1); tick();
        req_valid3 = 0; #1; chk("w3_wait", resp_valid3, 0); tick();
        flush3 = 1; #1;
        chk("w3_flush_ready", req_ready3, 0);
        chk("w3_flush_valid", resp_valid3, 0);
        tick();
        flush3 = 0; #1; chk("w3_idle_ready", req_ready3, 1); tick();
        for (int k = 0; k < 4; k++) begin
            #1; chk("w3_no_resp", resp_valid3, 0); tick();
        end
        req_valid3 = 1; req_pc3 = 32'h1000_0008; #1; tick();
        req_valid3 = 0; #1;
        chk("w3_imem_valid", resp_valid3, 1);
        chk("w3_imem_instr", resp_instr3, imem_word(14'd2));
        chk("w3_imem_err", resp_err3, 0);
        tick();

        // Counters: 5 accepts, 4 stalled cycles, then reset mid-WAIT.
        rst = 1; tick(); rst = 0;
        req_valid = 1; req_pc = 32'h1000_0000; resp_ready = 0; tick();
        repeat (4) tick();
        resp_ready = 1;
        for (int j = 1; j <= 4; j++) begin
            req_pc = 32'h1000_0000 + 32'(4 * j); tick();
        end
        req_valid = 0; tick(); #1;
`ifdef IFETCH_PERF_CNT_EN
        chk("cnt_fetch", fetch_cnt, 5);
        chk("cnt_stall", stall_cnt, 4);
`else
        chk("cnt_fetch_off", fetch_cnt, 0);
        chk("cnt_stall_off", stall_cnt, 0);
`endif
        tick();
        req_valid = 1; req_pc = 32'h4000_0000; tick();
        req_valid = 0; #1; chk("rst_wait_valid", resp_valid, 0);
        rst = 1; tick(); rst = 0; #1;
        chk("rst_mid_fetch", fetch_cnt, 0);
        chk("rst_mid_stall", stall_cnt, 0);
        chk("rst_mid_valid", resp_valid, 0);
        chk("rst_mid_instr", resp_instr, NOP);
        chk("rst_mid_ready", req_ready, 1);
        tick();
        #1; chk("rst_abandoned", resp_valid, 0); tick();

        // Random traffic against a timing-level model.
        have = 0; rdy_at = 0; m_pc = 0; m_instr = NOP; m_err = 0; m_fetch = 0; m_stall = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            req_valid  = ($urandom_range(0, 3) != 0);
            req_pc     = rand_pc();
            resp_ready = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 19) == 0);
            e_rv = have && (cyc >= rdy_at) && !flush;
            e_rr = !flush && (!have || ((cyc >= rdy_at) && resp_ready));
            acc  = req_valid && e_rr;
            scramble = e_rv && !acc;
            #1;
            chk("rnd_req_ready", req_ready, e_rr);
            chk("rnd_resp_valid", resp_valid, e_rv);
            if (e_rv) begin
                chk("rnd_resp_instr", resp_instr, m_instr);
                chk("rnd_resp_err", resp_err, m_err);
            end
            if (acc) begin
                chk("rnd_bios_addr", bios_addr, req_pc[13:2]);
                chk("rnd_imem_addr", imem_addr, req_pc[15:2]);
            end else if (have) begin
                chk("rnd_bios_addr_hold", bios_addr, m_pc[13:2]);
                chk("rnd_imem_addr_hold", imem_addr, m_pc[15:2]);
            end
            if (req_valid && !e_rr) m_stall++;
            if (flush || (e_rv && resp_ready)) have = 0;
            if (acc) begin
                have    = 1;
                m_pc    = req_pc;
                rdy_at  = cyc + lat_of(req_pc, 1);
                m_instr = word_of(req_pc);
                m_err   = err_of(req_pc);
                m_fetch++;
            end
            tick();
        end
        req_valid = 0; flush = 0; scramble = 0; #1;
`ifdef IFETCH_PERF_CNT_EN
        chk("rnd_fetch_cnt", fetch_cnt, 32'(m_fetch));
        chk("rnd_stall_cnt", stall_cnt, 32'(m_stall));
`else
        chk("rnd_fetch_cnt_off", fetch_cnt, 0);
        chk("rnd_stall_cnt_off", stall_cnt, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
